// File: rtl/mdu_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
package mdu_pkg;
  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;

  function automatic logic op_is_signed(input op_t o);
    return ~o[0];
  endfunction

  function automatic logic op_is_div(input op_t o);
    return o[1];
  endfunction
endpackage

// File: rtl/flopenr.sv
// Enabled register with asynchronous active-high reset.
module flopenr #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end
endmodule

// File: rtl/mdu_negate.sv
// Conditional two's-complement: q = en ? -d : d.
module mdu_negate #(
  parameter int WIDTH = 32
) (
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  assign q = en ? (~d + WIDTH'(1)) : d;
endmodule

// File: rtl/mdu_hilo.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO writes accepted
// PREP  | operands reduced to magnitudes, signs recorded
// RUN   | one shift-add / restoring shift-subtract step per cycle
// FIX   | sign correction, HI/LO commit, done pulse
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hilo_we,
  input  logic             hilo_sel,
  input  logic [WIDTH-1:0] hilo_wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  state_t               state;
  op_t                  op_q;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     opb;
  logic [CNT_W-1:0]     cnt;
  logic                 sign_q, sign_r, div0;

  logic [WIDTH-1:0]     acc_hi, acc_lo, abs_a, abs_b;
  logic [WIDTH-1:0]     quo_fix, rem_fix, res_hi, res_lo;
  logic [2*WIDTH-1:0]   prod_fix, acc_step;
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH+1:0]     add_x, add_y, sum;
  logic                 sgn, dv, ge;

  assign acc_hi = acc[2*WIDTH-1:WIDTH];
  assign acc_lo = acc[WIDTH-1:0];
  assign sgn    = op_is_signed(op_q);
  assign dv     = op_is_div(op_q);

  mdu_negate #(.WIDTH(WIDTH)) u_abs_a (.en(sgn & acc_lo[WIDTH-1]), .d(acc_lo), .q(abs_a));
  mdu_negate #(.WIDTH(WIDTH)) u_abs_b (.en(sgn & opb[WIDTH-1]),    .d(opb),    .q(abs_b));

  // Shared adder: accumulate for multiply, trial subtract for divide.
  assign rem_sh = {acc_hi, acc_lo[WIDTH-1]};
  assign add_x  = dv ? {1'b0, rem_sh} : {2'b00, acc_hi};
  assign add_y  = dv ? ~{2'b00, opb}  : {2'b00, opb};
  assign sum    = add_x + add_y + {{(WIDTH+1){1'b0}}, dv};
  assign ge     = ~sum[WIDTH+1];

  always_comb begin
    acc_step = acc;
    if (dv)
      acc_step = {(ge ? sum[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc_lo[WIDTH-2:0], ge};
    else if (acc_lo[0])
      acc_step = {sum[WIDTH:0], acc_lo[WIDTH-1:1]};
    else
      acc_step = {1'b0, acc_hi, acc_lo[WIDTH-1:1]};
  end

  // A zero divisor leaves the quotient all-ones and the dividend magnitude in
  // the remainder; re-applying the dividend sign restores the raw operand.
  mdu_negate #(.WIDTH(2*WIDTH)) u_neg_prod (.en(sgn & sign_q),         .d(acc),    .q(prod_fix));
  mdu_negate #(.WIDTH(WIDTH))   u_neg_quo  (.en(sgn & sign_q & ~div0), .d(acc_lo), .q(quo_fix));
  mdu_negate #(.WIDTH(WIDTH))   u_neg_rem  (.en(sgn & sign_r),         .d(acc_hi), .q(rem_fix));

  assign res_hi = dv ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
  assign res_lo = dv ? quo_fix : prod_fix[WIDTH-1:0];

  logic fix, mtx, hi_en, lo_en;
  logic [WIDTH-1:0] hi_d, lo_d;
  assign fix   = (state == FIX);
  assign mtx   = (state == IDLE) & hilo_we;
  assign hi_en = fix | (mtx & hilo_sel);
  assign lo_en = fix | (mtx & ~hilo_sel);
  assign hi_d  = fix ? res_hi : hilo_wd;
  assign lo_d  = fix ? res_lo : hilo_wd;

  flopenr #(.WIDTH(WIDTH)) u_hi (.clk(clk), .reset(reset), .en(hi_en), .d(hi_d), .q(hi));
  flopenr #(.WIDTH(WIDTH)) u_lo (.clk(clk), .reset(reset), .en(lo_en), .d(lo_d), .q(lo));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      op_q   <= OP_MULT;
      acc    <= '0;
      opb    <= '0;
      cnt    <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      div0   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          op_q  <= op_t'(op);
          acc   <= {{WIDTH{1'b0}}, a};
          opb   <= b;
          busy  <= 1'b1;
          state <= PREP;
        end
        PREP: begin
          acc    <= {{WIDTH{1'b0}}, abs_a};
          opb    <= abs_b;
          sign_q <= acc_lo[WIDTH-1] ^ opb[WIDTH-1];
          sign_r <= acc_lo[WIDTH-1];
          div0   <= (opb == '0);
          cnt    <= '0;
          state  <= RUN;
        end
        RUN: begin
          acc <= acc_step;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH-1)) state <= FIX;
        end
        FIX: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_hilo.sv
// Directed and reference-model checks for the HI/LO multiply/divide unit.
module tb_mdu_hilo;
  import mdu_pkg::*;

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0, hilo_wd = '0;
  logic        hilo_we = 1'b0, hilo_sel = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int tests = 0, failed = 0;

  mdu_hilo dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hilo_we(hilo_we), .hilo_sel(hilo_sel), .hilo_wd(hilo_wd),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] ux, uy, res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'h0, x};
    uy = {32'h0, y};
    res = '0;
    case (o)
      2'b00: res = sx * sy;
      2'b01: res = ux * uy;
      2'b10: if (y == 0) res = {x, 32'hFFFF_FFFF};
             else begin q = sx / sy; r = sx % sy; res = {r[31:0], q[31:0]}; end
      default: if (y == 0) res = {x, 32'hFFFF_FFFF};
               else res = {32'(ux % uy), 32'(ux / uy)};
    endcase
    return res;
  endfunction

  // Launches one op, waits for done (bounded), returns latency and HI seen right after launch.
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic we, input logic sel, input logic [31:0] wd,
                       output int lat, output logic [31:0] hi_e0);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    hilo_we = we; hilo_sel = sel; hilo_wd = wd;
    @(posedge clk); #1;
    start = 1'b0; hilo_we = 1'b0;
    a = 32'h5A5A_5A5A; b = 32'hA5A5_A5A5; op = ~o;
    hi_e0 = hi;
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 100) chk("done_timeout", 64'(lat), 64'd34);
  endtask

  int lat, dones, dl;
  logic [31:0] h0;
  logic [1:0]  ro;
  logic [31:0] ra, rb;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    @(negedge clk); reset = 1'b0;

    // MULTU max*max, with latency and single-cycle done
    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, lat, h0);
    chk("multu_lat", 64'(lat), 64'd34);
    chk("multu_res", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    chk("done_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk("done_pulse", 64'(done), 64'd0);

    do_op(OP_MULT, 32'hFFFF_FFF9, 32'd3, 0, 0, 0, lat, h0);
    chk("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, lat, h0);
    chk("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 0, 0, 0, lat, h0);
    chk("div_negb", {hi, lo}, 64'h0000_0001_FFFF_FFFD);
    do_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, 0, 0, 0, lat, h0);
    chk("mult_min", {hi, lo}, 64'h4000_0000_0000_0000);
    do_op(OP_DIVU, 32'd100, 32'd0, 0, 0, 0, lat, h0);
    chk("divu_by0", {hi, lo}, 64'h0000_0064_FFFF_FFFF);
    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd0, 0, 0, 0, lat, h0);
    chk("div_by0", {hi, lo}, 64'hFFFF_FFF9_FFFF_FFFF);
    do_op(OP_DIVU, 32'hFFFF_FFFF, 32'd16, 0, 0, 0, lat, h0);
    chk("divu_big", {hi, lo}, 64'h0000_000F_0FFF_FFFF);
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, lat, h0);
    chk("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);

    // Restarts and MTLO ignored while busy
    @(negedge clk); start = 1'b1; op = OP_MULTU; a = 32'd5; b = 32'd7;
    @(posedge clk); #1; start = 1'b0;
    dones = 0; dl = 0;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      start = (i == 5 || i == 10); op = OP_MULT; a = 32'd9; b = 32'd9;
      hilo_we = (i == 15); hilo_sel = 1'b0; hilo_wd = 32'hDEAD;
      @(posedge clk); #1;
      start = 1'b0; hilo_we = 1'b0;
      if (i == 15) chk("busy_we_drop", {hi, lo}, 64'h0000_0000_8000_0000);
      if (done) begin dones++; dl = i; end
    end
    chk("busy_dones", 64'(dones), 64'd1);
    chk("busy_dlat", 64'(dl), 64'd34);
    chk("busy_res", {hi, lo}, 64'h0000_0000_0000_0023);

    // MTLO in FIX dropped; MTHI in the done cycle accepted
    @(negedge clk); start = 1'b1; op = OP_MULTU; a = 32'd2; b = 32'd3;
    @(posedge clk); #1; start = 1'b0;
    dl = 0;
    for (int i = 1; i <= 36; i++) begin
      @(negedge clk);
      hilo_we = (i == 34 || i == 35); hilo_sel = (i == 35);
      hilo_wd = (i == 34) ? 32'hBEEF : 32'hCAFE;
      @(posedge clk); #1;
      hilo_we = 1'b0;
      if (done) dl = i;
      if (i == 34) chk("fix_we_drop", {hi, lo}, 64'h0000_0000_0000_0006);
    end
    chk("fix_dlat", 64'(dl), 64'd34);
    chk("idle_mthi", {hi, lo}, 64'h0000_CAFE_0000_0006);

    // Reset mid-op
    @(negedge clk); start = 1'b1; op = OP_MULTU; a = 32'd11; b = 32'd13;
    @(posedge clk); #1; start = 1'b0;
    repeat (16) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    #1;
    chk("abort_hilo", {hi, lo}, 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    @(negedge clk); reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("abort_nodone", 64'(dones), 64'd0);
    do_op(OP_MULTU, 32'd6, 32'd7, 0, 0, 0, lat, h0);
    chk("post_abort", {hi, lo}, 64'd42);

    // MTHI and start on the same edge
    do_op(OP_MULTU, 32'd2, 32'd3, 1, 1, 32'h1234, lat, h0);
    chk("mthi_start", 64'(h0), 64'h1234);
    chk("mthi_then_res", {hi, lo}, 64'd6);

    // Reference-model sweep
    for (int n = 0; n < 200; n++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (n % 17 == 0) ? 32'd0 : ((n % 5 == 0) ? 32'($urandom_range(1, 255)) : $urandom);
      if (n % 23 == 0) ra = 32'h8000_0000;
      do_op(ro, ra, rb, 0, 0, 0, lat, h0);
      chk($sformatf("rand%0d_op%0d", n, ro), {hi, lo}, ref_model(ro, ra, rb));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
